// File: rtl/task_15_pkg.sv
// Shared types and defaults for the task_15 packet sequencer.
package task_15_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int DEF_NUM_WORDS   = 50;
  localparam int DEF_SYS_LATENCY = 2;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/task_15_pulse_cnt.sv
// Enabled up-counter with synchronous clear and a terminal-count compare.
module task_15_pulse_cnt
  import task_15_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_tc  = (cnt_q == i_tc_val);

endmodule

// File: rtl/task_15_seq_ctrl.sv
// Packet sequencer: pops samples, strobes the system block, flushes its pipeline
// with zero pulses and writes exactly N results to the output buffer.
module task_15_seq_ctrl
  import task_15_pkg::*;
#(
  parameter int NUM_WORDS   = DEF_NUM_WORDS,
  parameter int SYS_LATENCY = DEF_SYS_LATENCY,
  parameter int CNT_W       = $clog2(NUM_WORDS + SYS_LATENCY + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_pkt_len,
  input  logic             i_in_empty,
  output logic             o_in_rd,
  output logic             o_sys_enb,
  output logic             o_sys_zero,
  input  logic [CNT_W-1:0] i_out_free,
  output logic             o_out_wr,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(SYS_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             wr_q, wr_d;
  logic             last_q, last_d;

  logic             enb;
  logic             cnt_clr;
  logic [CNT_W-1:0] p_cnt;
  logic             p_tc;
  logic [CNT_W-1:0] p_tc_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic [CNT_W-1:0] w_tc_val;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = CNT_W'(clamp_len(int'(i_pkt_len), NUM_WORDS));
  assign cnt_clr     = (state_q == ST_IDLE);
  // Last pulse index is N+SYS_LATENCY-2; the last write launched is index N-1.
  assign p_tc_val    = len_q + CNT_W'(SYS_LATENCY) - CNT_W'(2);
  assign w_tc_val    = len_q - CNT_W'(1);

  task_15_pulse_cnt #(.W(CNT_W)) u_pulse_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (cnt_clr),
    .i_en     (enb),
    .i_tc_val (p_tc_val),
    .o_cnt    (p_cnt),
    .o_tc     (p_tc)
  );

  // Counts writes as they are launched, one cycle ahead of o_out_wr.
  task_15_pulse_cnt #(.W(CNT_W)) u_write_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (cnt_clr),
    .i_en     (wr_d),
    .i_tc_val (w_tc_val),
    .o_cnt    (w_cnt),
    .o_tc     (w_tc)
  );

  // Free>=2 leaves room for the write still in flight from the previous pulse.
  always_comb begin
    enb        = 1'b0;
    o_in_rd    = 1'b0;
    o_sys_zero = 1'b0;
    if (!i_rst && (i_out_free >= CNT_W'(2))) begin
      case (state_q)
        ST_RUN:   enb = !i_in_empty;
        ST_DRAIN: enb = 1'b1;
        default:  enb = 1'b0;
      endcase
    end
    o_in_rd    = enb && (state_q == ST_RUN);
    o_sys_zero = !i_rst && (state_q == ST_DRAIN);
  end

  assign o_sys_enb = enb;
  assign wr_d      = enb && (p_cnt >= LAT_M1);
  assign last_d    = wr_d && w_tc;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          len_d   = len_clamped;
          state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (enb && (p_cnt == len_q - CNT_W'(1))) begin
          state_d = (SYS_LATENCY == 1) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enb && p_tc) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // All N writes launched; the final one is on o_out_wr this cycle.
        if (w_cnt == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
    end
  end

  assign o_out_wr   = wr_q;
  assign o_out_last = last_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_task_15_seq_ctrl.sv
// Randomized bench for task_15_seq_ctrl against a packet-level count model.
module tb_task_15_seq_ctrl;

  localparam int CNT_W = 6;
  localparam int L     = 2;
  localparam int NW    = 50;
  localparam int CAP   = 12;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_pkt_len = '0;
  logic             i_in_empty = 1'b0;
  logic             o_in_rd;
  logic             o_sys_enb;
  logic             o_sys_zero;
  logic [CNT_W-1:0] i_out_free = CNT_W'(CAP);
  logic             o_out_wr;
  logic             o_out_last;
  logic             o_busy;
  logic             o_done;

  always #5 clk = ~clk;

  task_15_seq_ctrl dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_pkt_len  (i_pkt_len),
    .i_in_empty (i_in_empty),
    .o_in_rd    (o_in_rd),
    .o_sys_enb  (o_sys_enb),
    .o_sys_zero (o_sys_zero),
    .i_out_free (i_out_free),
    .o_out_wr   (o_out_wr),
    .o_out_last (o_out_last),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Environment knobs
  bit chk_en      = 0;
  bit rand_empty  = 0;
  bit empty_force = 0;
  bit free_force  = 0;
  int free_val    = 0;
  bit drain_all   = 1;
  int occ         = 0;

  // Packet-level model: phase 0 idle, 1 pulsing, 2 awaiting last write, 3 done
  int m_phase = 0;
  int m_n = 0;
  int m_pulses = 0;
  int m_pops = 0;
  int m_wrs = 0;
  bit m_wr_now = 0;
  bit m_last_now = 0;
  int n_pkts = 0;

  always @(negedge clk) begin
    bit e_enb, e_rd, e_zero, wr_last_seen, nwr, nlast;
    int ln;
    e_enb = (m_phase == 1) && !i_rst && (int'(i_out_free) >= 2) &&
            ((m_pulses < m_n) ? !i_in_empty : 1'b1);
    e_rd   = e_enb && (m_pulses < m_n);
    e_zero = (m_pulses >= m_n);
    if (chk_en) begin
      check_val("enb",  32'(o_sys_enb), 32'(e_enb));
      check_val("rd",   32'(o_in_rd),   32'(e_rd));
      if (e_enb) check_val("zero", 32'(o_sys_zero), 32'(e_zero));
      check_val("wr",   32'(o_out_wr),  32'(m_wr_now));
      check_val("last", 32'(o_out_wr && o_out_last), 32'(m_wr_now && m_last_now));
      check_val("busy", 32'(o_busy), 32'(m_phase != 0));
      check_val("done", 32'(o_done), 32'(m_phase == 3));
      if (o_out_wr) begin
        check_val("wr_space", 32'(i_out_free != 0), 32'd1);
        check_val("ovf", 32'(occ < CAP), 32'd1);
      end
      if (o_in_rd)  m_pops++;
      if (o_out_wr) m_wrs++;
      if (m_phase == 3 && !i_rst) begin
        check_val("pkt_pops", 32'(m_pops), 32'(m_n));
        check_val("pkt_wrs",  32'(m_wrs),  32'(m_n));
        $display("packet %0d done: N=%0d pops=%0d writes=%0d", n_pkts, m_n, m_pops, m_wrs);
        n_pkts++;
      end
    end
    // output buffer occupancy after the coming edge
    wr_last_seen = m_wr_now && m_last_now;
    if (occ > 0 && (drain_all || $urandom_range(0, 1) == 1)) occ--;
    if (o_out_wr) occ++;
    if (i_rst) begin
      m_phase = 0; m_pulses = 0; m_wr_now = 0; m_last_now = 0;
    end else begin
      nwr   = e_enb && (m_pulses >= L - 1);
      nlast = nwr && (m_pulses - (L - 1) == m_n - 1);
      m_wr_now   = nwr;
      m_last_now = nlast;
      if (e_enb) m_pulses++;
      case (m_phase)
        0: if (i_start) begin
             ln = int'(i_pkt_len);
             m_n = (ln > NW) ? NW : ln;
             m_pulses = 0; m_pops = 0; m_wrs = 0;
             m_phase = (m_n == 0) ? 3 : 1;
           end
        1: if (m_pulses == m_n + L - 1) m_phase = (L == 1) ? 3 : 2;
        2: if (wr_last_seen) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    i_out_free = free_force ? CNT_W'(free_val) : CNT_W'(CAP - occ);
    i_in_empty = empty_force ? 1'b1 : (rand_empty && ($urandom_range(0, 3) == 0));
  endtask

  task automatic start_pkt(input int len);
    i_start   = 1'b1;
    i_pkt_len = CNT_W'(len);
    step();
    i_start   = 1'b0;
  endtask

  task automatic wait_pulses(input int k, input int budget);
    int c = 0;
    while (m_pulses < k && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) check_val("pulse_timeout", 32'(m_pulses), 32'(k));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (m_phase != 0 && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) check_val("idle_timeout", 32'(m_phase), 32'd0);
  endtask

  initial begin
    repeat (2) step();
    chk_en = 1;
    step();
    i_rst = 1'b0;
    @(negedge clk);
    check_val("rst_enb",  32'(o_sys_enb), 32'd0);
    check_val("rst_rd",   32'(o_in_rd),   32'd0);
    check_val("rst_zero", 32'(o_sys_zero), 32'd0);
    check_val("rst_wr",   32'(o_out_wr),  32'd0);
    check_val("rst_last", 32'(o_out_last), 32'd0);
    check_val("rst_busy", 32'(o_busy),    32'd0);
    check_val("rst_done", 32'(o_done),    32'd0);
    step();

    // N=5, no stalls
    start_pkt(5);
    wait_idle(100);
    // N=0
    start_pkt(0);
    wait_idle(20);
    // N=4 with a 3-cycle empty gap after pulse 1
    start_pkt(4);
    wait_pulses(2, 50);
    empty_force = 1;
    repeat (3) step();
    empty_force = 0;
    wait_idle(100);
    // Output space stuck at 1 mid-packet
    start_pkt(10);
    wait_pulses(3, 50);
    free_val = 1;
    free_force = 1;
    repeat (10) step();
    free_force = 0;
    wait_idle(200);
    // Oversized length clamps
    start_pkt(60);
    wait_idle(300);
    // Reset mid-packet, then a fresh packet
    start_pkt(8);
    wait_pulses(2, 50);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 32'(o_busy), 32'd0);
    check_val("abort_wr", 32'(o_out_wr), 32'd0);
    step();
    start_pkt(3);
    wait_idle(100);

    // Random traffic with stalls and stray starts
    rand_empty = 1;
    drain_all  = 0;
    for (int i = 0; i < 3000; i++) begin
      i_start   = ($urandom_range(0, 5) == 0);
      i_pkt_len = CNT_W'($urandom_range(0, 63));
      step();
    end
    i_start = 1'b0;
    drain_all = 1;
    wait_idle(1000);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
